sipo_deser_hs: RTL

- Parametrised serial-in/parallel-out deserialiser; successor to the fixed 4-bit SIPO shift register.
- Adds configurable width, MSB-first or LSB-first bit order, per-bit valid qualification, a frame-resync clear, a held output word with valid/ready handshake, and back-pressure on the serial side.
- Sits between a serial bit source (UART/SPI-style front end) and a parallel word consumer.

---
 rtl/deser_pkg.sv | 16 +
 rtl/sipo_shifter.sv | 64 ++++++
 rtl/sipo_deser_hs.sv | 72 +++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared definitions for the serial-in/parallel-out deserialiser family.
// Holds the bit-order encodings and the counter-width helper.
package deser_pkg;

    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

    // Bit counter width, clamped to 1 so degenerate widths still elaborate.
    function automatic int unsigned calc_cnt_w(input int unsigned width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_shifter.sv
// Serial shift register and bit counter for sipo_deser_hs.
// Produces the next shifter value so the top level can capture a completed word.
module sipo_shifter
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = ORDER_MSB_FIRST,
    localparam int unsigned CNT_W    = calc_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             accept_i,
    input  logic             data_i,
    output logic [WIDTH-1:0] sr_next_o,
    output logic             last_bit_o,
    output logic [CNT_W-1:0] bit_count_o
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        if (MSB_FIRST) begin
            sr_next_o = {sr_q[WIDTH-2:0], data_i};
        end else begin
            sr_next_o = {data_i, sr_q[WIDTH-1:1]};
        end
    end

    assign last_bit_o  = (cnt_q == LastCnt);
    assign bit_count_o = cnt_q;

    // Clear wins over an accepted bit; the final bit empties the shifter.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (accept_i) begin
            if (last_bit_o) begin
                sr_d  = '0;
                cnt_d = '0;
            end else begin
                sr_d  = sr_next_o;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sipo_deser_hs.sv
// Parametrised SIPO deserialiser with held output word and valid/ready handshake.
// The shifter keeps filling while a word is held; only the final bit can stall.
module sipo_deser_hs
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = ORDER_MSB_FIRST,
    localparam int unsigned CNT_W    = calc_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             data_in,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_count
);

    logic             accept;
    logic             last_bit;
    logic             complete;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    sipo_shifter #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear),
        .accept_i   (accept),
        .data_i     (data_in),
        .sr_next_o  (sr_next),
        .last_bit_o (last_bit),
        .bit_count_o(bit_count)
    );

    assign in_ready = !valid_q || out_ready || !last_bit;
    assign accept   = in_valid && in_ready;
    // A bit accepted during clear is discarded, so it cannot complete a word.
    assign complete = accept && last_bit && !clear;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (complete) begin
            data_d  = sr_next;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;

endmodule
